// File: rtl/machine_pkg.sv
// Shared definitions for the Machine run-control front-end.
// Holds mode encodings, the controller state set and the default bus widths.
package machine_pkg;

  localparam int unsigned MACHINE_AW = 30;
  localparam int unsigned MACHINE_DW = 32;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_HALTED  = 3'd0,
    ST_EXEC    = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ACK     = 3'd4,
    ST_FAULT   = 3'd5,
    ST_STOPPED = 3'd6
  } state_e;

  // Where to go once a step has completed.
  function automatic state_e step_next(input logic stop, input logic [1:0] mode);
    if (stop) return ST_STOPPED;
    if (mode == MODE_RUN) return ST_EXEC;
    return ST_HALTED;
  endfunction

endpackage

// File: rtl/machine_watchdog.sv
// Transaction watchdog: counts cycles spent in REQ/WAIT and flags the last
// permitted cycle so the controller can fault if nothing completes there.
module machine_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] cnt;

  // Saturates at TIMEOUT so it can never wrap back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNTW'(TIMEOUT))) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  // High during the TIMEOUT-th REQ/WAIT cycle of a transaction.
  assign expired_c = enable && (cnt >= CNTW'(TIMEOUT - 1));

endmodule

// File: rtl/machine_run_ctrl.sv
// Run control and RAM front-end for the Machine core: gates the step logic,
// forwards one memory transaction per step and reports status and step count.
module machine_run_ctrl
  import machine_pkg::*;
#(
  parameter int unsigned AW      = MACHINE_AW,
  parameter int unsigned DW      = MACHINE_DW,
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic [1:0]    mode,
  input  logic          step_pulse,
  input  logic          fault_clr,
  input  logic          core_req_valid,
  input  logic          core_req_we,
  input  logic [AW-1:0] core_req_addr,
  input  logic [DW-1:0] core_req_wdata,
  input  logic          core_halt,
  output logic          core_en,
  output logic          core_ack,
  output logic [DW-1:0] core_rdata,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_rdy,
  input  logic          ram_rvalid,
  input  logic [DW-1:0] ram_rdata,
  output logic          running,
  output logic          stopped,
  output logic          fault,
  output logic [CW-1:0] step_count
);

  state_e state_q, state_d;
  logic   pend_stop;
  logic   latch_req;
  logic   rdata_cap;
  logic   step_done;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;

  machine_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (system1000),
    .rst_n     (system1000_rstn),
    .clear     (wd_clear),
    .enable    (wd_enable),
    .expired_c (wd_expired)
  );

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) state_q <= ST_HALTED;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    rdata_cap = 1'b0;
    step_done = 1'b0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (mode == MODE_RUN) state_d = ST_EXEC;
        else if ((mode == MODE_STEP) && step_pulse) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (core_req_valid) begin
          latch_req = 1'b1;
          wd_clear  = 1'b1;
          state_d   = ST_REQ;
        end else begin
          step_done = 1'b1;
          state_d   = step_next(core_halt, mode);
        end
      end
      ST_REQ: begin
        wd_enable = 1'b1;
        // A write accepted on the last permitted cycle still completes.
        if (ram_rdy && ram_we) state_d = ST_ACK;
        else if (wd_expired)   state_d = ST_FAULT;
        else if (ram_rdy)      state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_enable = 1'b1;
        if (ram_rvalid) begin
          rdata_cap = 1'b1;
          state_d   = ST_ACK;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_ACK: begin
        step_done = 1'b1;
        state_d   = step_next(pend_stop, mode);
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_HALTED;
      end
      ST_STOPPED: state_d = ST_STOPPED;
      default:    state_d = ST_HALTED;
    endcase
  end

  // Status and strobes are registered from the next-state decode.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      core_en    <= 1'b0;
      core_ack   <= 1'b0;
      core_rdata <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      running    <= 1'b0;
      stopped    <= 1'b0;
      fault      <= 1'b0;
      step_count <= '0;
      pend_stop  <= 1'b0;
    end else begin
      core_en  <= (state_d == ST_EXEC);
      core_ack <= (state_d == ST_ACK);
      ram_req  <= (state_d == ST_REQ);
      running  <= (state_d inside {ST_EXEC, ST_REQ, ST_WAIT, ST_ACK});
      stopped  <= (state_d == ST_STOPPED);
      fault    <= (state_d == ST_FAULT);
      if (latch_req) begin
        ram_we    <= core_req_we;
        ram_addr  <= core_req_addr;
        ram_wdata <= core_req_wdata;
        pend_stop <= core_halt;
      end
      if (rdata_cap) core_rdata <= ram_rdata;
      if (step_done && (step_count != {CW{1'b1}})) step_count <= step_count + CW'(1);
    end
  end

endmodule

// File: doc/machine_run_ctrl.md
# machine_run_ctrl

Parametrised run-control and memory front-end for the Machine core. It gates execution of the combinational step logic (halt / free-run / single-step), forwards each step's single memory transaction to RAM under a ready/valid handshake with a watchdog timeout, and reports running, stopped and fault status plus a completed-step count. It sits between the step logic and the RAM port, replacing the fixed-width pass-through status path with configurable widths and explicit modes.

## Interface

- AW, 30: RAM word-address width
- DW, 32: data width
- CW, 32: step-counter width
- TIMEOUT, 255: maximum cycles a transaction may spend in REQ+WAIT, ≥1

- system1000  in  1  clock
- system1000_rstn  in  1  reset; asynchronous, active-low
- mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT
- step_pulse  in  1  one-cycle single-step request, used only in STEP
- fault_clr  in  1  clears FAULT
- core_req_valid / core_req_we  in  1 / 1  step logic requests a RAM access / it is a write
- core_req_addr / core_req_wdata  in  AW / DW  request fields
- core_halt  in  1  step logic executed a halt instruction
- core_en  out  1  step logic may advance its state this cycle
- core_ack  out  1  transaction complete, one-cycle pulse
- core_rdata  out  DW  read data, valid from core_ack until next completed read
- ram_req / ram_we  out  1 / 1  request valid / write
- ram_addr / ram_wdata  out  AW / DW  latched request fields
- ram_rdy / ram_rvalid  in  1 / 1  request accepted / read data valid
- ram_rdata  in  DW  read data
- running / stopped / fault  out  1 / 1 / 1  status
- step_count  out  CW  completed steps, saturating

## Operation

- States: HALTED, EXEC, REQ, WAIT, ACK, FAULT, STOPPED. Reset → HALTED.
- HALTED: core_en=0. mode=RUN → EXEC; mode=STEP and step_pulse → EXEC.
- EXEC: core_en=1 for exactly one cycle. If core_req_valid: latch we/addr/wdata, latch core_halt as pending-stop, → REQ. Otherwise step completes here: core_halt → STOPPED; else mode=RUN → EXEC; else → HALTED.
- REQ: ram_req=1 with latched fields, held stable until ram_rdy. On ram_rdy: write → ACK; read → WAIT.
- WAIT: ram_rvalid sampled only here; on ram_rvalid capture ram_rdata into core_rdata, → ACK.
- ACK: core_ack=1, core_en=0; step completes; pending-stop → STOPPED; else mode=RUN → EXEC; else → HALTED.
- Watchdog: counter cleared on EXEC→REQ, incremented each REQ/WAIT cycle; completion not seen within TIMEOUT cycles → FAULT, ram_req drops, step not counted.
- FAULT: fault=1, core_en=0; fault_clr → HALTED.
- STOPPED: stopped=1; exited only by reset.
- step_count +1 on every completed step; saturates at all-ones.
- running=1 in EXEC, REQ, WAIT, ACK.
- Mode change during REQ/WAIT does not abort the transaction; it takes effect at the step boundary. step_pulse outside HALTED/STEP is ignored.

## Timing

- Reset values: every output 0, state HALTED, core_rdata 0, watchdog 0, pending-stop 0.
- Step with no access: 1 cycle; free-run gives core_en high every cycle.
- Write, ram_rdy immediate: EXEC t0, REQ t1, ACK t2, next EXEC t3.
- Read, rvalid k≥1 cycles after accept: EXEC t0, REQ t1, WAIT t2..t1+k, ACK t2+k.
- Timeout exact: with TIMEOUT=N and no completion, FAULT entered on cycle N+1 after REQ entry.
- Reset mid-transaction: ram_req deasserts asynchronously; nothing completes.

## Structure

- Shared package machine_pkg: mode encodings, state enumeration, default AW/DW.
- One sub-module: machine_watchdog (clear/enable/expired, parameter TIMEOUT, width $clog2(TIMEOUT+1)).

## Test plan

- Reset, mode=RUN, core_req_valid=0 for 10 cycles → core_en high 10 cycles, step_count=10.
- mode=STEP, write to addr 0x5 data 0xDEADBEEF, ram_rdy immediate → ram_req 1 cycle at t1, core_ack at t2, state HALTED, step_count=1.
- Read addr 0x10, ram_rvalid 3 cycles after accept, ram_rdata 0x1234 → core_ack at t5, core_rdata=0x1234.
- TIMEOUT=4, ram_rdy held low → fault=1 at cycle 5 after REQ entry, ram_req=0; fault_clr → HALTED, step_count unchanged.
- core_halt with a pending read → stopped=1 only after core_ack; RUN thereafter has no effect until reset.
- CW=4, free-run 20 steps → step_count=15; assert reset mid-REQ → ram_req=0 immediately, all outputs 0.
